// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync timing monitor.
// Recovers line/frame position from the hsync/vsync pair, measures every line
// period and sync pulse width against nominal timing, and reports lock status,
// one-cycle error pulses and a saturating error counter.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL_CLKS  = 3200,
    parameter int unsigned H_PULSE_CLKS  = 384,
    parameter int unsigned V_TOTAL_LINES = 525,
    parameter int unsigned V_PULSE_CLKS  = 6400,
    parameter int unsigned TOL           = 4,
    parameter int unsigned LOCK_FRAMES   = 2,
    parameter logic        SYNC_POL      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        locked,
    output logic [9:0]  line_count,
    output logic [11:0] h_period,
    output logic        frame_done,
    output logic        h_err,
    output logic        v_err,
    output logic        timeout,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // All clock-count measurements are compared in a common 14-bit domain.
    localparam logic [13:0] H_TOT_C      = 14'(H_TOTAL_CLKS);
    localparam logic [13:0] H_PW_C       = 14'(H_PULSE_CLKS);
    localparam logic [13:0] V_PW_C       = 14'(V_PULSE_CLKS);
    localparam logic [13:0] TOL_C        = 14'(TOL);
    localparam logic [10:0] V_TOT_C      = 11'(V_TOTAL_LINES);
    // The idle counter is wider than h_clk so that twice the nominal line
    // period stays reachable even when h_clk itself has saturated.
    localparam logic [12:0] TO_LIMIT_C   = 13'(2 * H_TOTAL_CLKS);
    localparam logic [7:0]  LOCK_C       = 8'(LOCK_FRAMES);
    localparam logic        SYNC_INACT_C = ~SYNC_POL;

    // True when a measurement deviates from nominal by more than the tolerance.
    function automatic logic out_of_tol(input logic [13:0] meas,
                                        input logic [13:0] nom,
                                        input logic [13:0] tol);
        logic [13:0] diff;
        if (meas >= nom) begin
            diff = meas - nom;
        end else begin
            diff = nom - meas;
        end
        return (diff > tol);
    endfunction

    state_t      state_q, state_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] h_clk_q, h_clk_d;
    logic [12:0] idle_q, idle_d;
    logic [11:0] hw_q, hw_d;
    logic [12:0] vw_q, vw_d;
    logic [9:0]  line_q, line_d;
    logic        h_seen_q, h_seen_d;
    logic        v_seen_q, v_seen_d;
    logic        frame_bad_q, frame_bad_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        locked_q, locked_d;
    logic [11:0] h_period_q, h_period_d;
    logic        frame_done_q, frame_done_d;
    logic        h_err_q, h_err_d;
    logic        v_err_q, v_err_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        hs_act_s, hs_prev_act_s, h_rise_s, h_fall_s;
    logic        vs_act_s, vs_prev_act_s, v_rise_s, v_fall_s;
    logic [13:0] h_meas_s;
    logic [10:0] lines_s;
    logic        any_err_s;
    logic        frame_good_s;

    // Edge detection, measurement counters, error flags and the lock FSM.
    always_comb begin
        hs_act_s      = (hsync_in == SYNC_POL);
        hs_prev_act_s = (hs_q == SYNC_POL);
        vs_act_s      = (vsync_in == SYNC_POL);
        vs_prev_act_s = (vs_q == SYNC_POL);
        h_rise_s      = hs_act_s & ~hs_prev_act_s;
        h_fall_s      = ~hs_act_s & hs_prev_act_s;
        v_rise_s      = vs_act_s & ~vs_prev_act_s;
        v_fall_s      = ~vs_act_s & vs_prev_act_s;

        hs_d = hsync_in;
        vs_d = vsync_in;

        // Line period: distance between successive hsync assertion edges.
        h_meas_s = {2'b00, h_clk_q} + 14'd1;
        if (h_rise_s) begin
            h_clk_d = 12'd0;
            if (h_clk_q == 12'd4095) begin
                h_period_d = 12'd4095;
            end else begin
                h_period_d = h_clk_q + 12'd1;
            end
        end else begin
            h_period_d = h_period_q;
            if (h_clk_q == 12'd4095) begin
                h_clk_d = h_clk_q;
            end else begin
                h_clk_d = h_clk_q + 12'd1;
            end
        end

        // Idle counter for hsync loss; a single match gives a single pulse.
        if (h_rise_s) begin
            idle_d = 13'd0;
        end else if (idle_q == 13'd8191) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 13'd1;
        end
        timeout_d = (idle_q == TO_LIMIT_C) & ~h_rise_s;

        // hsync pulse width: the assertion cycle counts as the first cycle.
        if (h_rise_s) begin
            hw_d = 12'd1;
        end else if (hs_act_s) begin
            if (hw_q == 12'd4095) begin
                hw_d = hw_q;
            end else begin
                hw_d = hw_q + 12'd1;
            end
        end else begin
            hw_d = 12'd0;
        end

        // vsync pulse width, same scheme as hsync.
        if (v_rise_s) begin
            vw_d = 13'd1;
        end else if (vs_act_s) begin
            if (vw_q == 13'd8191) begin
                vw_d = vw_q;
            end else begin
                vw_d = vw_q + 13'd1;
            end
        end else begin
            vw_d = 13'd0;
        end

        // The very first edges after reset have no reference, so are not judged.
        h_seen_d = h_seen_q | h_rise_s;
        v_seen_d = v_seen_q | v_rise_s;

        h_err_d = (h_rise_s & h_seen_q & out_of_tol(h_meas_s, H_TOT_C, TOL_C))
                | (h_fall_s & out_of_tol({2'b00, hw_q}, H_PW_C, TOL_C));

        // A coincident hsync edge belongs to the frame that is ending.
        lines_s = {1'b0, line_q} + {10'd0, h_rise_s};
        v_err_d = (v_rise_s & v_seen_q & (lines_s != V_TOT_C))
                | (v_fall_s & out_of_tol({1'b0, vw_q}, V_PW_C, TOL_C));

        if (v_rise_s) begin
            line_d = 10'd0;
        end else if (h_rise_s) begin
            if (line_q == 10'd1023) begin
                line_d = line_q;
            end else begin
                line_d = line_q + 10'd1;
            end
        end else begin
            line_d = line_q;
        end

        any_err_s    = h_err_d | v_err_d | timeout_d;
        frame_good_s = ~frame_bad_q & ~any_err_s;
        frame_done_d = v_rise_s;
        if (v_rise_s) begin
            frame_bad_d = 1'b0;
        end else begin
            frame_bad_d = frame_bad_q | any_err_s;
        end

        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_SEARCH: begin
                frame_cnt_d = 8'd0;
                if (v_rise_s) begin
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_ALIGN: begin
                // At a frame boundary the ending frame is judged in place;
                // errors anywhere else abandon alignment.
                if (v_rise_s) begin
                    if (frame_good_s) begin
                        if ((frame_cnt_q + 8'd1) >= LOCK_C) begin
                            state_d     = ST_LOCKED;
                            frame_cnt_d = 8'd0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end else begin
                        frame_cnt_d = 8'd0;
                    end
                end else if (any_err_s) begin
                    state_d     = ST_SEARCH;
                    frame_cnt_d = 8'd0;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_LOCKED: begin
                if (any_err_s) begin
                    state_d     = ST_SEARCH;
                    frame_cnt_d = 8'd0;
                    if (err_count_q == 8'd255) begin
                        err_count_d = err_count_q;
                    end else begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d     = ST_SEARCH;
                frame_cnt_d = 8'd0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            hs_q         <= SYNC_INACT_C;
            vs_q         <= SYNC_INACT_C;
            h_clk_q      <= 12'd0;
            idle_q       <= 13'd0;
            hw_q         <= 12'd0;
            vw_q         <= 13'd0;
            line_q       <= 10'd0;
            h_seen_q     <= 1'b0;
            v_seen_q     <= 1'b0;
            frame_bad_q  <= 1'b0;
            frame_cnt_q  <= 8'd0;
            locked_q     <= 1'b0;
            h_period_q   <= 12'd0;
            frame_done_q <= 1'b0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            timeout_q    <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            h_clk_q      <= h_clk_d;
            idle_q       <= idle_d;
            hw_q         <= hw_d;
            vw_q         <= vw_d;
            line_q       <= line_d;
            h_seen_q     <= h_seen_d;
            v_seen_q     <= v_seen_d;
            frame_bad_q  <= frame_bad_d;
            frame_cnt_q  <= frame_cnt_d;
            locked_q     <= locked_d;
            h_period_q   <= h_period_d;
            frame_done_q <= frame_done_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            timeout_q    <= timeout_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = locked_q;
    assign line_count = line_q;
    assign h_period   = h_period_q;
    assign frame_done = frame_done_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign timeout    = timeout_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using scaled-down timing so that many
// frames fit in a short run. Frames are described in a table and applied in a
// loop; timeout, counter saturation and mid-frame reset are hand sequences.
module tb_vga_sync_monitor;

    localparam int TB_H   = 16;   // clk per line
    localparam int TB_HP  = 4;    // hsync width
    localparam int TB_VL  = 3;    // lines per frame
    localparam int TB_VP  = 24;   // vsync width in clk
    localparam int TB_TOL = 1;

    logic        clk;
    logic        reset;
    logic        hsync_in;
    logic        vsync_in;
    logic        locked;
    logic [9:0]  line_count;
    logic [11:0] h_period;
    logic        frame_done;
    logic        h_err;
    logic        v_err;
    logic        timeout;
    logic [7:0]  err_count;

    vga_sync_monitor #(
        .H_TOTAL_CLKS (TB_H),
        .H_PULSE_CLKS (TB_HP),
        .V_TOTAL_LINES(TB_VL),
        .V_PULSE_CLKS (TB_VP),
        .TOL          (TB_TOL),
        .LOCK_FRAMES  (2),
        .SYNC_POL     (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .locked    (locked),
        .line_count(line_count),
        .h_period  (h_period),
        .frame_done(frame_done),
        .h_err     (h_err),
        .v_err     (v_err),
        .timeout   (timeout),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int nl;     // lines in frame
        int per;    // nominal line period
        int bl;     // index of odd line (-1 none)
        int bp;     // period of odd line
        int hw;     // hsync width
        int vw;     // vsync width
        int e_herr; // h_err pulses seen in this frame window
        int e_verr;
        int e_lock; // locked at end of frame
        int e_ec;   // err_count at end of frame
        int e_hper; // h_period at end of frame
        int e_lc;   // line_count at end of frame
        int e_rise; // locked rises on the first cycle of this frame
    } frame_vec_t;

    int n_chk = 0;
    int n_err = 0;
    int ncyc = 0;
    int n_herr, n_verr, n_to;
    int lock_at, to_at;
    int f_start;
    logic lk_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then observe the registered response.
    task automatic cyc(input logic h, input logic v);
        hsync_in = h;
        vsync_in = v;
        @(negedge clk);
        ncyc++;
        if (h_err) n_herr++;
        if (v_err) n_verr++;
        if (timeout) begin
            n_to++;
            to_at = ncyc;
        end
        if (locked && !lk_prev) lock_at = ncyc;
        lk_prev = locked;
    endtask

    // One frame, active-low syncs; vsync and first hsync assert together.
    task automatic run_frame(input int nl, input int per, input int bl, input int bp,
                             input int hw, input int vw);
        int c;
        int p;
        c = 0;
        f_start = ncyc + 1;
        for (int l = 0; l < nl; l++) begin
            p = (l == bl) ? bp : per;
            for (int k = 0; k < p; k++) begin
                cyc((k < hw) ? 1'b0 : 1'b1, (c < vw) ? 1'b0 : 1'b1);
                c++;
            end
        end
    endtask

    task automatic nominal_frame();
        run_frame(TB_VL, TB_H, -1, TB_H, TB_HP, TB_VP);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_line_count"}, int'(line_count), 0);
        chk({tag, "_h_period"}, int'(h_period), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_h_err"}, int'(h_err), 0);
        chk({tag, "_v_err"}, int'(v_err), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
    endtask

    frame_vec_t vt[23];

    initial begin
        int e_hedge;
        int exp_ec;
        //       nl  per bl  bp  hw  vw  herr verr lock ec hper lc rise
        vt[0]  = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 0, 16, 2, 0};
        vt[1]  = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 0, 16, 2, 0};
        vt[2]  = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 0, 16, 2, 1};
        vt[3]  = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 0, 16, 2, 0};
        vt[4]  = '{3, 16,  1, 18, 4, 24, 1, 0, 0, 1, 18, 2, 0};
        vt[5]  = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 1, 16, 2, 0};
        vt[6]  = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 1, 16, 2, 0};
        vt[7]  = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 1, 16, 2, 1};
        vt[8]  = '{2, 16, -1, 16, 4, 24, 0, 0, 1, 1, 16, 1, 0};
        vt[9]  = '{3, 16, -1, 16, 4, 24, 0, 1, 0, 2, 16, 2, 0};
        vt[10] = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 2, 16, 2, 0};
        vt[11] = '{2, 16, -1, 16, 4, 24, 0, 0, 0, 2, 16, 1, 0};
        vt[12] = '{3, 16, -1, 16, 4, 24, 0, 1, 0, 2, 16, 2, 0};
        vt[13] = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 2, 16, 2, 0};
        vt[14] = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 2, 16, 2, 1};
        vt[15] = '{3, 17, -1, 17, 5, 23, 0, 0, 1, 2, 17, 2, 0};
        vt[16] = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 2, 16, 2, 0};
        vt[17] = '{3, 18, -1, 18, 4, 24, 2, 0, 0, 3, 18, 2, 0};
        vt[18] = '{3, 16, -1, 16, 6, 24, 4, 0, 0, 3, 16, 2, 0};
        vt[19] = '{3, 16, -1, 16, 4, 26, 0, 1, 0, 3, 16, 2, 0};
        vt[20] = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 3, 16, 2, 0};
        vt[21] = '{3, 16, -1, 16, 4, 24, 0, 0, 0, 3, 16, 2, 0};
        vt[22] = '{3, 16, -1, 16, 4, 24, 0, 0, 1, 3, 16, 2, 1};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        chk_all_zero("reset");
        reset = 1'b0;

        // Table-driven frames: lock, line error, short frames, tolerance edges.
        for (int i = 0; i < 23; i++) begin
            n_herr  = 0;
            n_verr  = 0;
            lock_at = -1;
            run_frame(vt[i].nl, vt[i].per, vt[i].bl, vt[i].bp, vt[i].hw, vt[i].vw);
            chk($sformatf("f%0d_h_err", i), n_herr, vt[i].e_herr);
            chk($sformatf("f%0d_v_err", i), n_verr, vt[i].e_verr);
            chk($sformatf("f%0d_locked", i), int'(locked), vt[i].e_lock);
            chk($sformatf("f%0d_err_count", i), int'(err_count), vt[i].e_ec);
            chk($sformatf("f%0d_h_period", i), int'(h_period), vt[i].e_hper);
            chk($sformatf("f%0d_line_count", i), int'(line_count), vt[i].e_lc);
            chk($sformatf("f%0d_lock_rise", i), lock_at, vt[i].e_rise ? f_start : -1);
        end

        // hsync loss while locked: one timeout pulse exactly 2*H after the last edge.
        e_hedge = f_start + 2 * TB_H;
        n_to  = 0;
        to_at = -1;
        for (int j = 0; j < 60; j++) cyc(1'b1, 1'b1);
        chk("timeout_count", n_to, 1);
        chk("timeout_cycle", to_at, e_hedge + 2 * TB_H + 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_err_count", int'(err_count), 4);

        for (int j = 0; j < 4; j++) nominal_frame();
        chk("relock_after_timeout", int'(locked), 1);

        // Repeated error/relock cycles drive err_count into saturation.
        exp_ec = 4;
        for (int it = 0; it < 255; it++) begin
            run_frame(TB_VL, TB_H, 1, TB_H + 2, TB_HP, TB_VP);
            exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            chk($sformatf("sat_it%0d_err_count", it), int'(err_count), exp_ec);
            for (int j = 0; j < 3; j++) nominal_frame();
        end
        chk("sat_locked", int'(locked), 1);
        chk("sat_final", int'(err_count), 255);

        // Reset in the middle of a frame clears everything on the next cycle.
        for (int k = 0; k < 20; k++) cyc((k < TB_HP) ? 1'b0 : 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        reset = 1'b0;
        chk_all_zero("midreset");
        lock_at = -1;
        for (int j = 0; j < 3; j++) nominal_frame();
        chk("post_reset_lock_rise", lock_at, f_start);
        chk("post_reset_err_count", int'(err_count), 0);
        chk("post_reset_h_period", int'(h_period), TB_H);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
